alu_issue_stage: RTL and testbench

//  Operand-issue stage directly upstream of the ALU. Accepts decoded ops and reads rs1/rs2 via the

---
 rtl/alu_issue_stage_pkg.sv | 43 ++++
 rtl/alu_issue_stage_operand_fwd_mux.sv | 54 +++++
 rtl/alu_issue_stage.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU operand-issue stage.
//   - ALU opcode constants (alu_op_e) and register-index width
//   - skid FSM state encoding: bit0 = OUT holds an op, bit1 = SKID holds an op
//   - issue_ctrl_t: non-operand payload carried with each buffered op
package alu_issue_stage_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned OPCODE_W  = 5;

  typedef enum logic [OPCODE_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_MUL  = 5'd10,
    ALU_MULH = 5'd11,
    ALU_DIV  = 5'd12,
    ALU_DIVU = 5'd13,
    ALU_REM  = 5'd14,
    ALU_REMU = 5'd15
  } alu_op_e;

  // Encoding chosen so valid flags are plain flop bits of the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic                 s_32;
    logic [REG_IDX_W-1:0] rd_idx;
    logic                 rd_we;
  } issue_ctrl_t;

endpackage

// File: rtl/alu_issue_stage_operand_fwd_mux.sv
// operand_fwd_mux: per-source operand select and RAW hazard detect.
// Configuration macro: ISSUE_BYPASS_EN
//   defined   : x0 -> 0, else MEM result, else WB result, else regfile; hazard only on load-use
//   undefined : x0 -> 0, else regfile; hazard on any MEM/WB destination match
// Ports:
//   idx, rf_data                         source index and same-cycle regfile data
//   mem_rd_we/mem_is_load/mem_rd_idx/mem_result, wb_rd_we/wb_rd_idx/wb_result
//   value  (out) selected operand, hazard (out) op must stall
module operand_fwd_mux
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]      rf_data,
  input  logic                 mem_rd_we,
  input  logic                 mem_is_load,
  input  logic [REG_IDX_W-1:0] mem_rd_idx,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 wb_rd_we,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]      wb_result,
  output logic [XLEN-1:0]      value,
  output logic                 hazard
);

  logic idx_nz;
  logic mem_hit;
  logic wb_hit;

  assign idx_nz  = (idx != '0);
  assign mem_hit = idx_nz && mem_rd_we && (idx == mem_rd_idx);
  assign wb_hit  = idx_nz && wb_rd_we && (idx == wb_rd_idx);

`ifdef ISSUE_BYPASS_EN
  // MEM is younger than WB, so it wins when both target the same register.
  always_comb begin
    value = rf_data;
    if (!idx_nz)      value = '0;
    else if (mem_hit) value = mem_result;
    else if (wb_hit)  value = wb_result;
  end

  // A load's data is not ready in MEM; only that case cannot be forwarded.
  assign hazard = mem_hit && mem_is_load;
`else
  logic unused_bypass;
  assign unused_bypass = ^{mem_is_load, mem_result, wb_result};

  assign value  = idx_nz ? rf_data : '0;
  assign hazard = mem_hit || wb_hit;
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand-issue stage in front of the ALU.
// Reads rs1/rs2 from the regfile, resolves RAW hazards (forward or stall), and
// presents registered opcode/s_32/operands through a two-entry valid/ready skid buffer.
// Configuration macro: ISSUE_BYPASS_EN (enables MEM/WB forwarding, see operand_fwd_mux).
// Ports:
//   clk, rst (async, active-high), flush (drop all buffered ops)
//   in_*          decoded op handshake and fields
//   rf_rs*_addr   combinational regfile read addresses, rf_rs*_data same-cycle data
//   mem_*, wb_*   later-stage destinations/results for hazard and forwarding
//   out_*         registered ALU-side handshake and fields
//   stall_cycles  saturating count of cycles an op was held by a hazard
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPCODE_W-1:0]  in_opcode,
  input  logic                 in_s_32,
  input  logic [REG_IDX_W-1:0] in_rs1_idx,
  input  logic [REG_IDX_W-1:0] in_rs2_idx,
  input  logic                 in_use_imm,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [REG_IDX_W-1:0] in_rd_idx,
  input  logic                 in_rd_we,
  output logic [REG_IDX_W-1:0] rf_rs1_addr,
  output logic [REG_IDX_W-1:0] rf_rs2_addr,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  input  logic                 mem_rd_we,
  input  logic                 mem_is_load,
  input  logic [REG_IDX_W-1:0] mem_rd_idx,
  input  logic [XLEN-1:0]      mem_result,
  input  logic                 wb_rd_we,
  input  logic [REG_IDX_W-1:0] wb_rd_idx,
  input  logic [XLEN-1:0]      wb_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  out_opcode,
  output logic                 out_s_32,
  output logic [XLEN-1:0]      out_rs1,
  output logic [XLEN-1:0]      out_rs2,
  output logic [REG_IDX_W-1:0] out_rd_idx,
  output logic                 out_rd_we,
  output logic [CNT_W-1:0]     stall_cycles
);

  skid_state_e state_q, state_d;
  issue_ctrl_t out_ctrl_q, out_ctrl_d;
  issue_ctrl_t skid_ctrl_q, skid_ctrl_d;
  logic [XLEN-1:0]  out_rs1_q, out_rs1_d;
  logic [XLEN-1:0]  out_rs2_q, out_rs2_d;
  logic [XLEN-1:0]  skid_rs1_q, skid_rs1_d;
  logic [XLEN-1:0]  skid_rs2_q, skid_rs2_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic [XLEN-1:0] rs1_val, rs2_fwd_val, rs2_val;
  logic            rs1_hz, rs2_hz, hazard;
  logic            skid_valid, accept;
  issue_ctrl_t     in_ctrl;

  assign rf_rs1_addr = in_rs1_idx;
  assign rf_rs2_addr = in_rs2_idx;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .idx        (in_rs1_idx),
    .rf_data    (rf_rs1_data),
    .mem_rd_we  (mem_rd_we),
    .mem_is_load(mem_is_load),
    .mem_rd_idx (mem_rd_idx),
    .mem_result (mem_result),
    .wb_rd_we   (wb_rd_we),
    .wb_rd_idx  (wb_rd_idx),
    .wb_result  (wb_result),
    .value      (rs1_val),
    .hazard     (rs1_hz)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .idx        (in_rs2_idx),
    .rf_data    (rf_rs2_data),
    .mem_rd_we  (mem_rd_we),
    .mem_is_load(mem_is_load),
    .mem_rd_idx (mem_rd_idx),
    .mem_result (mem_result),
    .wb_rd_we   (wb_rd_we),
    .wb_rd_idx  (wb_rd_idx),
    .wb_result  (wb_result),
    .value      (rs2_fwd_val),
    .hazard     (rs2_hz)
  );

  // An immediate replaces rs2, so rs2 can neither supply data nor cause a stall.
  assign rs2_val = in_use_imm ? in_imm : rs2_fwd_val;
  assign hazard  = rs1_hz || (rs2_hz && !in_use_imm);

  assign skid_valid = state_q[1];
  assign in_ready   = !skid_valid && !hazard && !flush;
  assign accept     = in_valid && in_ready;

  always_comb begin
    in_ctrl.opcode = in_opcode;
    in_ctrl.s_32   = in_s_32;
    in_ctrl.rd_idx = in_rd_idx;
    in_ctrl.rd_we  = in_rd_we;
  end

  // Next-state: skid buffer control and saturating stall counter.
  always_comb begin
    state_d     = state_q;
    out_ctrl_d  = out_ctrl_q;
    out_rs1_d   = out_rs1_q;
    out_rs2_d   = out_rs2_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_rs1_d  = skid_rs1_q;
    skid_rs2_d  = skid_rs2_q;
    stall_d     = stall_q;

    if (in_valid && hazard && !flush && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_ctrl_d = in_ctrl;
            out_rs1_d  = rs1_val;
            out_rs2_d  = rs2_val;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_ready) begin
            if (accept) begin
              out_ctrl_d = in_ctrl;
              out_rs1_d  = rs1_val;
              out_rs2_d  = rs2_val;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (accept) begin
            skid_ctrl_d = in_ctrl;
            skid_rs1_d  = rs1_val;
            skid_rs2_d  = rs2_val;
            state_d     = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            out_ctrl_d = skid_ctrl_q;
            out_rs1_d  = skid_rs1_q;
            out_rs2_d  = skid_rs2_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      out_ctrl_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      skid_ctrl_q <= '0;
      skid_rs1_q  <= '0;
      skid_rs2_q  <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rs1_q   <= out_rs1_d;
      out_rs2_q   <= out_rs2_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_rs1_q  <= skid_rs1_d;
      skid_rs2_q  <= skid_rs2_d;
      stall_q     <= stall_d;
    end
  end

  assign out_valid    = state_q[0];
  assign out_opcode   = out_ctrl_q.opcode;
  assign out_s_32     = out_ctrl_q.s_32;
  assign out_rd_idx   = out_ctrl_q.rd_idx;
  assign out_rd_we    = out_ctrl_q.rd_we;
  assign out_rs1      = out_rs1_q;
  assign out_rs2      = out_rs2_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based reference model. Honors ISSUE_BYPASS_EN the same way as the RTL.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, in_s_32, in_use_imm, in_rd_we;
  logic [4:0]      in_opcode, in_rs1_idx, in_rs2_idx, in_rd_idx;
  logic [XLEN-1:0] in_imm, rf_rs1_data, rf_rs2_data, mem_result, wb_result;
  logic [4:0]      rf_rs1_addr, rf_rs2_addr, mem_rd_idx, wb_rd_idx;
  logic            mem_rd_we, mem_is_load, wb_rd_we;
  logic            out_valid, out_ready, out_s_32, out_rd_we;
  logic [4:0]      out_opcode, out_rd_idx;
  logic [XLEN-1:0] out_rs1, out_rs2;
  logic [CNT_W-1:0] stall_cycles;

  alu_issue_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_s_32(in_s_32),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_use_imm(in_use_imm), .in_imm(in_imm),
    .in_rd_idx(in_rd_idx), .in_rd_we(in_rd_we),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .mem_rd_we(mem_rd_we), .mem_is_load(mem_is_load), .mem_rd_idx(mem_rd_idx), .mem_result(mem_result),
    .wb_rd_we(wb_rd_we), .wb_rd_idx(wb_rd_idx), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_s_32(out_s_32),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd_idx(out_rd_idx), .out_rd_we(out_rd_we),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: ops held by the stage, oldest first (at most two).
  typedef struct {
    logic [4:0]      op;
    logic            s32;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd;
    logic            we;
  } mop_t;

  mop_t            mq[$];
  logic [CNT_W-1:0] mstall = '0;

  function automatic logic [XLEN-1:0] m_opnd(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
`ifdef ISSUE_BYPASS_EN
    if (mem_rd_we && idx == mem_rd_idx) return mem_result;
    if (wb_rd_we && idx == wb_rd_idx) return wb_result;
`endif
    return rf;
  endfunction

  function automatic bit m_src_hz(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
`ifdef ISSUE_BYPASS_EN
    return mem_is_load && mem_rd_we && (idx == mem_rd_idx);
`else
    return (mem_rd_we && idx == mem_rd_idx) || (wb_rd_we && idx == wb_rd_idx);
`endif
  endfunction

  function automatic bit m_hazard();
    return m_src_hz(in_rs1_idx) || (!in_use_imm && m_src_hz(in_rs2_idx));
  endfunction

  // Compare every cycle, then advance the model for the coming rising edge.
  always @(negedge clk) begin
    mop_t e;
    bit   hz, rdy;
    if (rst) begin
      mq.delete();
      mstall = '0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_stall", stall_cycles, 0);
      chk("rst_out_data", {out_rs1, out_rs2}, 0);
      chk("rst_out_ctrl", {out_opcode, out_s_32, out_rd_idx, out_rd_we}, 0);
    end else begin
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_opcode", out_opcode, mq[0].op);
        chk("out_s_32", out_s_32, mq[0].s32);
        chk("out_rs1", out_rs1, mq[0].a);
        chk("out_rs2", out_rs2, mq[0].b);
        chk("out_rd", {out_rd_idx, out_rd_we}, {mq[0].rd, mq[0].we});
      end
      chk("stall_cycles", stall_cycles, mstall);
    end
    hz  = m_hazard();
    rdy = (mq.size() < 2) && !hz && !flush;
    chk("in_ready", in_ready, rdy);
    chk("rf_addr", {rf_rs1_addr, rf_rs2_addr}, {in_rs1_idx, in_rs2_idx});
    if (!rst) begin
      if (in_valid && hz && !flush && mstall != CNT_MAX) mstall = mstall + 1'b1;
      if (flush) mq.delete();
      else begin
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (in_valid && rdy) begin
          e.op  = in_opcode;
          e.s32 = in_s_32;
          e.a   = m_opnd(in_rs1_idx, rf_rs1_data);
          e.b   = in_use_imm ? in_imm : m_opnd(in_rs2_idx, rf_rs2_data);
          e.rd  = in_rd_idx;
          e.we  = in_rd_we;
          mq.push_back(e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #2;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_opcode = '0; in_s_32 = 0; in_rs1_idx = '0; in_rs2_idx = '0;
    in_use_imm = 0; in_imm = '0; in_rd_idx = '0; in_rd_we = 0; rf_rs1_data = '0; rf_rs2_data = '0;
    mem_rd_we = 0; mem_is_load = 0; mem_rd_idx = '0; mem_result = '0;
    wb_rd_we = 0; wb_rd_idx = '0; wb_result = '0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    in_valid = 1; in_opcode = op; in_rs1_idx = r1; in_rs2_idx = r2;
    rf_rs1_data = d1; rf_rs2_data = d2; in_rd_idx = 5'd9; in_rd_we = 1;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); rst = 0; cyc();
  endtask

  initial begin
    idle(); out_ready = 1; rst = 1;
    cyc(); cyc();
    look();
    chk("lit_reset_in_ready", in_ready, 1);
    chk("lit_reset_out_valid", out_valid, 0);
    chk("lit_reset_stall", stall_cycles, 0);
    rst = 0; cyc();

    // Plain ADD from regfile data.
    set_op(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7);
    look(); chk("lit_t1_in_ready", in_ready, 1);
    cyc(); in_valid = 0;
    look();
    chk("lit_t1_out_valid", out_valid, 1);
    chk("lit_t1_rs1", out_rs1, 32'd5);
    chk("lit_t1_rs2", out_rs2, 32'd7);
    chk("lit_t1_opcode", out_opcode, ALU_ADD);
    cyc();

    // MEM and WB both target x1.
    mem_rd_we = 1; mem_rd_idx = 5'd1; mem_result = 32'hAA;
    wb_rd_we = 1; wb_rd_idx = 5'd1; wb_result = 32'hBB;
    set_op(ALU_SUB, 5'd1, 5'd2, 32'd5, 32'd7);
`ifdef ISSUE_BYPASS_EN
    look(); chk("lit_t2_in_ready", in_ready, 1);
    cyc(); idle();
    look(); chk("lit_t2_rs1_mem_wins", out_rs1, 32'hAA);
`else
    look(); chk("lit_t2_stall_no_bypass", in_ready, 0);
    cyc(); idle();
    look(); chk("lit_t2_not_accepted", out_valid, 0);
`endif
    cyc();

    // x0 never forwards.
    mem_rd_we = 1; mem_rd_idx = 5'd0; mem_result = 32'h55;
    set_op(ALU_OR, 5'd0, 5'd0, 32'h99, 32'h99);
    look(); chk("lit_t3_in_ready", in_ready, 1);
    cyc(); idle();
    look(); chk("lit_t3_rs1_zero", out_rs1, 32'd0);
    cyc();

    // Load-use stall for two cycles.
    do_reset();
    mem_is_load = 1; mem_rd_we = 1; mem_rd_idx = 5'd3;
    set_op(ALU_AND, 5'd3, 5'd0, 32'h3, 32'h0);
    look(); chk("lit_t4_stall_c1", in_ready, 0);
    cyc();
    look(); chk("lit_t4_stall_c2", in_ready, 0);
    cyc(); mem_is_load = 0; mem_rd_we = 0;
    look();
    chk("lit_t4_stall_cnt", stall_cycles, 2);
    chk("lit_t4_ready_again", in_ready, 1);
    cyc(); idle();
    look(); chk("lit_t4_issued", out_valid, 1);
    cyc();

    // Backpressure fills the skid; ops leave in order.
    out_ready = 0;
    set_op(ALU_XOR, 5'd4, 5'd0, 32'h11, 32'h0);
    cyc();
    set_op(ALU_XOR, 5'd4, 5'd0, 32'h22, 32'h0);
    look(); chk("lit_t5_second_ready", in_ready, 1);
    cyc(); idle();
    look();
    chk("lit_t5_full_not_ready", in_ready, 0);
    chk("lit_t5_head_a", out_rs1, 32'h11);
    cyc(); out_ready = 1;
    look(); chk("lit_t5_first_out", out_rs1, 32'h11);
    cyc();
    look(); chk("lit_t5_second_out", out_rs1, 32'h22);
    cyc();
    look(); chk("lit_t5_drained", out_valid, 0);

    // Flush while full drops everything and refuses the new op.
    cyc(); out_ready = 0;
    set_op(ALU_SLL, 5'd6, 5'd0, 32'h1, 32'h0);
    cyc();
    set_op(ALU_SLL, 5'd6, 5'd0, 32'h2, 32'h0);
    cyc();
    set_op(ALU_SLL, 5'd6, 5'd0, 32'h3, 32'h0);
    flush = 1; out_ready = 1;
    look(); chk("lit_t6_flush_in_ready", in_ready, 0);
    cyc(); idle();
    look();
    chk("lit_t6_out_empty", out_valid, 0);
    chk("lit_t6_in_ready", in_ready, 1);
    cyc();

    // Counter saturation.
    do_reset();
    mem_is_load = 1; mem_rd_we = 1; mem_rd_idx = 5'd5;
    set_op(ALU_ADD, 5'd5, 5'd0, 32'h0, 32'h0);
    repeat (70) cyc();
    look(); chk("lit_stall_saturated", stall_cycles, CNT_MAX);
    cyc(); idle(); do_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 999) == 0);
      flush       = ($urandom_range(0, 99) < 4);
      in_valid    = ($urandom_range(0, 9) < 7);
      out_ready   = ($urandom_range(0, 9) < 6);
      in_opcode   = 5'($urandom_range(0, 31));
      in_s_32     = 1'($urandom);
      in_rs1_idx  = 5'($urandom_range(0, 3));
      in_rs2_idx  = 5'($urandom_range(0, 3));
      in_use_imm  = ($urandom_range(0, 3) == 0);
      in_imm      = $urandom;
      in_rd_idx   = 5'($urandom);
      in_rd_we    = 1'($urandom);
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      mem_rd_we   = 1'($urandom);
      mem_is_load = ($urandom_range(0, 9) < 3);
      mem_rd_idx  = 5'($urandom_range(0, 3));
      mem_result  = $urandom;
      wb_rd_we    = 1'($urandom);
      wb_rd_idx   = 5'($urandom_range(0, 3));
      wb_result   = $urandom;
      cyc();
    end
    rst = 0; idle(); out_ready = 1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
